// File: rtl/tpu_cmd_bridge.sv
// Command bridge between a host command stream and a small systolic MLP: loads
// weight FIFOs, injects the first activation, sequences runs and snapshots results.
module tpu_cmd_bridge #(
    parameter int         NUM_COLS    = 2,
    parameter int         DATA_W      = 8,
    parameter int         ACT_W       = 16,
    parameter int         ACC_W       = 32,
    parameter int         W_PER_LOAD  = NUM_COLS * NUM_COLS,
    parameter logic [3:0] MLP_DONE    = 4'd0,
    parameter int         RUN_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [2:0]                cmd_op,
    input  logic [31:0]               cmd_data,
    output logic                      cmd_ready,
    output logic [NUM_COLS-1:0]       wf_push,
    output logic [DATA_W-1:0]         wf_data,
    output logic                      wf_reset,
    output logic                      act_valid,
    output logic [ACT_W-1:0]          act_data,
    output logic                      start_mlp,
    output logic                      weights_ready,
    output logic [15:0]               norm_gain,
    output logic [31:0]               norm_bias,
    output logic [4:0]                norm_shift,
    output logic [15:0]               q_inv_scale,
    output logic [7:0]                q_zero_point,
    input  logic [3:0]                mlp_state,
    input  logic                      mlp_acc_valid,
    input  logic [NUM_COLS*ACC_W-1:0] mlp_acc,
    output logic                      snap_valid,
    output logic [NUM_COLS*ACC_W-1:0] snap_data,
    input  logic                      snap_ready,
    output logic                      snap_overrun,
    output logic                      err
);

    localparam int CPW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int WCW = $clog2(W_PER_LOAD + 1);
    localparam int RCW = $clog2(RUN_TIMEOUT + 1);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WEIGHT = 3'd1;
    localparam logic [2:0] OP_ACT    = 3'd2;
    localparam logic [2:0] OP_GAIN   = 3'd3;
    localparam logic [2:0] OP_BIAS   = 3'd4;
    localparam logic [2:0] OP_QUANT  = 3'd5;
    localparam logic [2:0] OP_START  = 3'd6;
    localparam logic [2:0] OP_CLEAR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CPW-1:0]        r_col_ptr;
    logic [WCW-1:0]        r_wcnt;
    logic [RCW-1:0]        r_run_cnt;
    logic [NUM_COLS-1:0]   r_wf_push;
    logic [DATA_W-1:0]     r_wf_data;
    logic                  r_wf_reset;
    logic                  r_act_valid;
    logic [ACT_W-1:0]      r_act_data;
    logic                  r_start;
    logic                  r_wready;
    logic                  r_err;

    logic [CPW-1:0]        w_col_ptr_nxt;
    logic [WCW-1:0]        w_wcnt_nxt;
    logic [RCW-1:0]        w_run_cnt_nxt;
    logic [NUM_COLS-1:0]   w_wf_push_nxt;
    logic [DATA_W-1:0]     w_wf_data_nxt;
    logic                  w_wf_reset_nxt;
    logic                  w_act_valid_nxt;
    logic [ACT_W-1:0]      w_act_data_nxt;
    logic                  w_start_nxt;
    logic                  w_wready_nxt;
    logic                  w_err_nxt;

    logic [15:0]           r_gain;
    logic [31:0]           r_bias;
    logic [4:0]            r_shift;
    logic [15:0]           r_inv_scale;
    logic [7:0]            r_zero_point;

    logic                  r_snap_valid;
    logic [NUM_COLS*ACC_W-1:0] r_snap_data;
    logic                  r_snap_overrun;

    logic                  w_accept;
    logic                  w_clear;
    logic [WCW-1:0]        w_wcnt_inc;
    logic                  w_run_done;
    logic                  w_run_timeout;

    // Only CLEAR may interrupt a run; everything else is back-pressured.
    assign cmd_ready     = (r_state != ST_RUN) || (cmd_op == OP_CLEAR);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_clear       = w_accept && (cmd_op == OP_CLEAR);
    assign w_wcnt_inc    = r_wcnt + WCW'(1);
    assign w_run_done    = (r_state == ST_RUN) && (r_run_cnt >= RCW'(2)) && (mlp_state == MLP_DONE);
    assign w_run_timeout = (r_state == ST_RUN) && (r_run_cnt == RCW'(RUN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept && (cmd_op == OP_WEIGHT)) begin
                        w_state_nxt = (w_wcnt_inc == WCW'(W_PER_LOAD)) ? ST_READY : ST_LOAD;
                    end
                end
                ST_READY: begin
                    if (w_accept && (cmd_op == OP_START)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_run_done || w_run_timeout) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_col_ptr_nxt   = r_col_ptr;
        w_wcnt_nxt      = r_wcnt;
        w_run_cnt_nxt   = '0;
        w_wf_push_nxt   = '0;
        w_wf_data_nxt   = r_wf_data;
        w_wf_reset_nxt  = 1'b0;
        w_act_valid_nxt = 1'b0;
        w_act_data_nxt  = r_act_data;
        w_start_nxt     = 1'b0;
        w_wready_nxt    = r_wready;
        w_err_nxt       = r_err;

        if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
            w_run_cnt_nxt = r_run_cnt + RCW'(1);
        end

        if (w_run_done || w_run_timeout) begin
            w_col_ptr_nxt = '0;
            w_wcnt_nxt    = '0;
            w_wready_nxt  = 1'b0;
            if (!w_run_done) begin
                w_err_nxt = 1'b1;
            end
        end

        if (w_accept) begin
            case (cmd_op)
                OP_WEIGHT: begin
                    if (r_state == ST_READY) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_wf_push_nxt = NUM_COLS'(1) << r_col_ptr;
                        w_wf_data_nxt = cmd_data[DATA_W-1:0];
                        w_col_ptr_nxt = (r_col_ptr == CPW'(NUM_COLS - 1)) ? '0 : r_col_ptr + CPW'(1);
                        w_wcnt_nxt    = w_wcnt_inc;
                        if (w_wcnt_inc == WCW'(W_PER_LOAD)) begin
                            w_wready_nxt = 1'b1;
                        end
                    end
                end
                OP_ACT: begin
                    w_act_valid_nxt = 1'b1;
                    w_act_data_nxt  = cmd_data[ACT_W-1:0];
                end
                OP_START: begin
                    if (r_state == ST_READY) begin
                        w_start_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    w_wf_reset_nxt = 1'b1;
                    w_col_ptr_nxt  = '0;
                    w_wcnt_nxt     = '0;
                    w_run_cnt_nxt  = '0;
                    w_wready_nxt   = 1'b0;
                    w_err_nxt      = 1'b0;
                end
                OP_NOP, OP_GAIN, OP_BIAS, OP_QUANT: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_ptr   <= '0;
            r_wcnt      <= '0;
            r_run_cnt   <= '0;
            r_wf_push   <= '0;
            r_wf_data   <= '0;
            r_wf_reset  <= 1'b0;
            r_act_valid <= 1'b0;
            r_act_data  <= '0;
            r_start     <= 1'b0;
            r_wready    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_col_ptr   <= w_col_ptr_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_run_cnt   <= w_run_cnt_nxt;
            r_wf_push   <= w_wf_push_nxt;
            r_wf_data   <= w_wf_data_nxt;
            r_wf_reset  <= w_wf_reset_nxt;
            r_act_valid <= w_act_valid_nxt;
            r_act_data  <= w_act_data_nxt;
            r_start     <= w_start_nxt;
            r_wready    <= w_wready_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // CFG_GAIN carries only the low half of the bias; the high half is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain       <= 16'h0100;
            r_bias       <= '0;
            r_shift      <= 5'd8;
            r_inv_scale  <= 16'h0100;
            r_zero_point <= '0;
        end else if (w_accept) begin
            case (cmd_op)
                OP_GAIN: begin
                    r_gain       <= cmd_data[15:0];
                    r_bias[15:0] <= cmd_data[31:16];
                end
                OP_BIAS: begin
                    r_bias <= cmd_data;
                end
                OP_QUANT: begin
                    r_inv_scale  <= cmd_data[15:0];
                    r_shift      <= cmd_data[20:16];
                    r_zero_point <= cmd_data[31:24];
                end
                default: ;
            endcase
        end
    end

    // A fresh capture always wins over the consumer's pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_valid   <= 1'b0;
            r_snap_data    <= '0;
            r_snap_overrun <= 1'b0;
        end else begin
            if (w_clear) begin
                r_snap_overrun <= 1'b0;
            end
            if (mlp_acc_valid) begin
                r_snap_data  <= mlp_acc;
                r_snap_valid <= 1'b1;
                if (r_snap_valid && !snap_ready) begin
                    r_snap_overrun <= 1'b1;
                end
            end else if (snap_ready) begin
                r_snap_valid <= 1'b0;
            end
        end
    end

    assign wf_push       = r_wf_push;
    assign wf_data       = r_wf_data;
    assign wf_reset      = r_wf_reset;
    assign act_valid     = r_act_valid;
    assign act_data      = r_act_data;
    assign start_mlp     = r_start;
    assign weights_ready = r_wready;
    assign norm_gain     = r_gain;
    assign norm_bias     = r_bias;
    assign norm_shift    = r_shift;
    assign q_inv_scale   = r_inv_scale;
    assign q_zero_point  = r_zero_point;
    assign snap_valid    = r_snap_valid;
    assign snap_data     = r_snap_data;
    assign snap_overrun  = r_snap_overrun;
    assign err           = r_err;

endmodule

// File: tb/tb_tpu_cmd_bridge.sv
// Directed bench for tpu_cmd_bridge with hand-computed expected values.
module tb_tpu_cmd_bridge;

    localparam int NUM_COLS    = 2;
    localparam int DATA_W      = 8;
    localparam int ACT_W       = 16;
    localparam int ACC_W       = 32;
    localparam int RUN_TIMEOUT = 4096;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      cmd_valid = 1'b0;
    logic [2:0]                cmd_op = 3'd0;
    logic [31:0]               cmd_data = '0;
    logic                      cmd_ready;
    logic [NUM_COLS-1:0]       wf_push;
    logic [DATA_W-1:0]         wf_data;
    logic                      wf_reset;
    logic                      act_valid;
    logic [ACT_W-1:0]          act_data;
    logic                      start_mlp;
    logic                      weights_ready;
    logic [15:0]               norm_gain;
    logic [31:0]               norm_bias;
    logic [4:0]                norm_shift;
    logic [15:0]               q_inv_scale;
    logic [7:0]                q_zero_point;
    logic [3:0]                mlp_state = 4'd0;
    logic                      mlp_acc_valid = 1'b0;
    logic [NUM_COLS*ACC_W-1:0] mlp_acc = '0;
    logic                      snap_valid;
    logic [NUM_COLS*ACC_W-1:0] snap_data;
    logic                      snap_ready = 1'b0;
    logic                      snap_overrun;
    logic                      err;

    int n_cmp = 0;
    int n_mis = 0;

    tpu_cmd_bridge #(
        .NUM_COLS(NUM_COLS), .DATA_W(DATA_W), .ACT_W(ACT_W), .ACC_W(ACC_W),
        .W_PER_LOAD(NUM_COLS*NUM_COLS), .MLP_DONE(4'd0), .RUN_TIMEOUT(RUN_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .wf_push(wf_push), .wf_data(wf_data), .wf_reset(wf_reset),
        .act_valid(act_valid), .act_data(act_data), .start_mlp(start_mlp),
        .weights_ready(weights_ready),
        .norm_gain(norm_gain), .norm_bias(norm_bias), .norm_shift(norm_shift),
        .q_inv_scale(q_inv_scale), .q_zero_point(q_zero_point),
        .mlp_state(mlp_state), .mlp_acc_valid(mlp_acc_valid), .mlp_acc(mlp_acc),
        .snap_valid(snap_valid), .snap_data(snap_data), .snap_ready(snap_ready),
        .snap_overrun(snap_overrun), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
    endtask

    task automatic load_weights(input logic [31:0] base);
        for (int i = 0; i < NUM_COLS*NUM_COLS; i++) begin
            send(3'd1, base + 32'(i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_val("rst_push", wf_push, 0);
        check_val("rst_wready", weights_ready, 0);
        check_val("rst_err", err, 0);
        check_val("rst_snapv", snap_valid, 0);
        check_val("rst_snapd", snap_data, 0);
        check_val("rst_gain", norm_gain, 16'h0100);
        check_val("rst_shift", norm_shift, 8);
        check_val("rst_invsc", q_inv_scale, 16'h0100);
        check_val("rst_ready", cmd_ready, 1);

        send(3'd1, 32'h11);
        check_val("w1_push", wf_push, 2'b01);
        check_val("w1_data", wf_data, 8'h11);
        check_val("w1_wready", weights_ready, 0);
        send(3'd1, 32'h22);
        check_val("w2_push", wf_push, 2'b10);
        check_val("w2_data", wf_data, 8'h22);
        send(3'd1, 32'h33);
        check_val("w3_push", wf_push, 2'b01);
        check_val("w3_data", wf_data, 8'h33);
        check_val("w3_wready", weights_ready, 0);
        send(3'd1, 32'h44);
        check_val("w4_push", wf_push, 2'b10);
        check_val("w4_data", wf_data, 8'h44);
        check_val("w4_wready", weights_ready, 1);
        tick();
        check_val("w_idle_push", wf_push, 0);

        send(3'd2, 32'h0000BEEF);
        check_val("act_valid", act_valid, 1);
        check_val("act_data", act_data, 16'hBEEF);
        tick();
        check_val("act_pulse", act_valid, 0);

        send(3'd5, 32'h050A0200);
        check_val("q_invsc", q_inv_scale, 16'h0200);
        check_val("q_shift", norm_shift, 10);
        check_val("q_zp", q_zero_point, 5);
        send(3'd3, 32'h12340200);
        check_val("g_gain", norm_gain, 16'h0200);
        check_val("g_bias", norm_bias, 32'h00001234);
        send(3'd4, 32'hAABBCCDD);
        check_val("b_bias", norm_bias, 32'hAABBCCDD);
        send(3'd3, 32'h56780300);
        check_val("g2_gain", norm_gain, 16'h0300);
        check_val("g2_bias", norm_bias, 32'hAABB5678);

        // Run: mlp_state idle in the first two RUN cycles must not end it
        send(3'd6, 32'h0);
        check_val("run_start", start_mlp, 1);
        cmd_op = 3'd1;
        #1;
        check_val("run_rdy_t0", cmd_ready, 0);
        tick();
        check_val("run_start_off", start_mlp, 0);
        check_val("run_rdy_t1", cmd_ready, 0);
        mlp_state = 4'd3;
        tick();
        tick();
        check_val("run_rdy_t3", cmd_ready, 0);
        check_val("run_wready", weights_ready, 1);
        mlp_state = 4'd0;
        tick();
        check_val("run_exit_rdy", cmd_ready, 1);
        check_val("run_exit_wready", weights_ready, 0);
        check_val("run_exit_err", err, 0);
        cmd_op = 3'd0;

        send(3'd6, 32'h0);
        check_val("idle_start", start_mlp, 0);
        check_val("idle_start_err", err, 1);
        send(3'd7, 32'h0);
        check_val("clr_wfrst", wf_reset, 1);
        check_val("clr_err", err, 0);
        check_val("clr_gain", norm_gain, 16'h0300);
        tick();
        check_val("clr_wfrst_off", wf_reset, 0);

        load_weights(32'hA0);
        check_val("rl_wready", weights_ready, 1);
        check_val("rl_data", wf_data, 8'hA3);
        send(3'd1, 32'h55);
        check_val("rdyw_push", wf_push, 0);
        check_val("rdyw_err", err, 1);
        check_val("rdyw_wready", weights_ready, 1);
        send(3'd7, 32'h0);

        mlp_acc_valid = 1'b1;
        mlp_acc = 64'h0000_0001_0000_0002;
        tick();
        mlp_acc_valid = 1'b0;
        check_val("snap1_v", snap_valid, 1);
        check_val("snap1_d", snap_data, 64'h0000_0001_0000_0002);
        check_val("snap1_ovr", snap_overrun, 0);
        mlp_acc_valid = 1'b1;
        mlp_acc = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        mlp_acc_valid = 1'b0;
        check_val("snap2_d", snap_data, 64'hDEAD_BEEF_0BAD_F00D);
        check_val("snap2_ovr", snap_overrun, 1);
        mlp_acc_valid = 1'b1;
        mlp_acc = 64'h1111_2222_3333_4444;
        snap_ready = 1'b1;
        tick();
        mlp_acc_valid = 1'b0;
        check_val("snap3_v", snap_valid, 1);
        check_val("snap3_d", snap_data, 64'h1111_2222_3333_4444);
        check_val("snap3_ovr", snap_overrun, 1);
        tick();
        snap_ready = 1'b0;
        check_val("snap_pop_v", snap_valid, 0);
        send(3'd7, 32'h0);
        check_val("snap_clr_ovr", snap_overrun, 0);
        check_val("snap_clr_d", snap_data, 64'h1111_2222_3333_4444);

        load_weights(32'h10);
        send(3'd6, 32'h0);
        mlp_state = 4'd3;
        cmd_op = 3'd1;
        #1;
        n = 0;
        while (!cmd_ready && n < RUN_TIMEOUT + 20) begin
            tick();
            n++;
        end
        check_val("to_exited", cmd_ready, 1);
        check_val("to_cycles", n, RUN_TIMEOUT);
        check_val("to_err", err, 1);
        check_val("to_wready", weights_ready, 0);
        cmd_op = 3'd0;
        mlp_state = 4'd0;

        load_weights(32'h20);
        send(3'd6, 32'h0);
        mlp_state = 4'd3;
        mlp_acc_valid = 1'b1;
        mlp_acc = 64'h5;
        tick();
        mlp_acc_valid = 1'b0;
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'd7;
        tick();
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 3'd1;
        #1;
        check_val("mrst_wfrst", wf_reset, 0);
        check_val("mrst_start", start_mlp, 0);
        check_val("mrst_ready", cmd_ready, 1);
        check_val("mrst_err", err, 0);
        check_val("mrst_wready", weights_ready, 0);
        check_val("mrst_snapv", snap_valid, 0);
        check_val("mrst_snapd", snap_data, 0);
        check_val("mrst_gain", norm_gain, 16'h0100);
        check_val("mrst_bias", norm_bias, 0);
        cmd_op = 3'd0;
        mlp_state = 4'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tpu_cmd_bridge.md
TPU_CMD_BRIDGE -- requirements
Module: tpu_cmd_bridge

Interface
REQ-001 Parameters (name, default, meaning): NUM_COLS 2 weight columns; DATA_W 8 weight byte width; ACT_W 16 activation width; ACC_W 32 accumulator width; W_PER_LOAD NUM_COLS*NUM_COLS weight bytes per load; MLP_DONE 4'd0 MLP idle/done state code; RUN_TIMEOUT 4096 max RUN cycles.
REQ-002 Ports (name direction width meaning): clk in 1 clock; rst in 1 reset.
REQ-003 cmd_valid in 1 command present; cmd_op in 3 opcode; cmd_data in 32 payload; cmd_ready out 1 command accepted when valid&ready.
REQ-004 wf_push out NUM_COLS one-hot column push; wf_data out DATA_W weight byte; wf_reset out 1 FIFO clear pulse.
REQ-005 act_valid out 1, act_data out ACT_W initial activation; start_mlp out 1 start pulse; weights_ready out 1 weights loaded.
REQ-006 norm_gain out 16, norm_bias out 32, norm_shift out 5, q_inv_scale out 16, q_zero_point out 8: activation-pipeline config.
REQ-007 mlp_state in 4 MLP state; mlp_acc_valid in 1; mlp_acc in NUM_COLS*ACC_W accumulators, column 0 in LSBs.
REQ-008 snap_valid out 1, snap_data out NUM_COLS*ACC_W, snap_ready in 1 result handshake; snap_overrun out 1 sticky; err out 1 sticky protocol error.
REQ-009 One clock (clk); reset rst synchronous, active-high.

Function
REQ-010 Opcodes: 0 NOP; 1 WEIGHT (cmd_data[DATA_W-1:0]); 2 ACT (cmd_data[ACT_W-1:0]); 3 CFG_GAIN ({bias[15:0],gain}); 4 CFG_BIAS (full 32-bit bias); 5 CFG_QUANT ({zp[7:0],shift[4:0] at [20:16],inv_scale}); 6 START; 7 CLEAR.
REQ-011 FSM states IDLE, LOAD, READY, RUN; cmd_ready=1 in IDLE/LOAD/READY; in RUN cmd_ready=1 only when cmd_op==7.
REQ-012 Accepted WEIGHT: next cycle wf_push has single bit col_ptr set for 1 cycle, wf_data=byte; col_ptr increments, wraps NUM_COLS-1 -> 0; weight counter increments.
REQ-013 IDLE + WEIGHT -> LOAD; counter reaching W_PER_LOAD -> READY, weights_ready=1 from that cycle until RUN exits or CLEAR.
REQ-014 WEIGHT in READY: ignored (no push), err set.
REQ-015 Accepted ACT: act_valid=1 one cycle later for 1 cycle, act_data=payload; allowed IDLE/LOAD/READY.
REQ-016 CFG ops update config registers, visible next cycle; 3 CFG_GAIN writes gain and bias[15:0] only; bias[31:16] unchanged.
REQ-017 START in READY: start_mlp 1-cycle pulse next cycle, -> RUN; START in other states ignored, err set.
REQ-018 RUN exit: first cycle mlp_state==MLP_DONE occurring at least 2 cycles after start_mlp -> IDLE, weights_ready=0, counters/col_ptr=0.
REQ-019 RUN cycle counter reaching RUN_TIMEOUT: -> IDLE as REQ-018, err set.
REQ-020 CLEAR (any state, incl. RUN): wf_reset 1-cycle pulse next cycle, -> IDLE, counters/col_ptr/weights_ready/err/snap_overrun=0; config and snapshot kept.
REQ-021 Snapshot: mlp_acc_valid loads snap_data next cycle, snap_valid=1; capture independent of FSM state.
REQ-022 snap_valid&snap_ready clears snap_valid; simultaneous capture wins (snap_valid stays 1, new data, no overrun).
REQ-023 Capture while snap_valid=1 and snap_ready=0: overwrite data, snap_overrun=1 sticky.
REQ-024 All outputs registered except cmd_ready; at most one push/act/start pulse per cycle.

Reset
REQ-025 rst: state IDLE; all pulses, weights_ready, snap_valid, snap_overrun, err, counters, col_ptr, snap_data=0.
REQ-026 Reset config: norm_gain=16'h0100, norm_bias=0, norm_shift=8, q_inv_scale=16'h0100, q_zero_point=0.
REQ-027 rst mid-RUN or mid-LOAD aborts immediately, no start_mlp/wf_reset pulse emitted; rst overrides any command that cycle.

Verification
REQ-028 Reset, 4 WEIGHT bytes 0x11,0x22,0x33,0x44 -> wf_push 01,10,01,10 with those bytes; weights_ready=1 after 4th.
REQ-029 START in READY, mlp_state 0->3->0 -> one start_mlp pulse, RUN, cmd_ready=0 for op 1, IDLE on return to 0, weights_ready=0.
REQ-030 START in IDLE -> no start_mlp, err=1; CLEAR -> wf_reset pulse, err=0, norm_gain unchanged.
REQ-031 Two mlp_acc_valid pulses, snap_ready=0 -> snap_data = second value, snap_overrun=1; capture with snap_ready=1 -> snap_valid stays 1, overrun unchanged.
REQ-032 CFG_QUANT 0x05_0A_0200 -> q_inv_scale=0x0200, norm_shift=10, q_zero_point=5 next cycle.
REQ-033 START, mlp_state held 3 for RUN_TIMEOUT cycles -> IDLE, err=1.
